// File: rtl/pack_ctrl.sv
// Sequencer that feeds one byte from each PE result port (PE0..PE3, strict order)
// into the shared 4-byte packer and writes each packed word to output SRAM.
module pack_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        pe_valid,
  input  logic [95:0]       pe_data,
  output logic [3:0]        pe_ready,
  output logic              pk_in_valid,
  output logic              pk_clear,
  output logic [23:0]       pk_in_data,
  input  logic [31:0]       pk_out_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t            state_reg;
  logic [1:0]        slot_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic [ADDR_W-1:0] num_words_reg;
  logic [ADDR_W-1:0] base_addr_reg;

  logic [23:0] pe_word [4];
  logic [3:0]  slot_onehot;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pe
      assign pe_word[gi]     = pe_data[gi*24 +: 24];
      assign slot_onehot[gi] = (slot_reg == 2'(gi));
    end
  endgenerate

  logic active;
  logic collecting;
  logic accept;
  logic writing;
  logic last_word;

  // abort only has meaning while a job is running
  assign active     = (state_reg != IDLE);
  assign collecting = (state_reg == COLLECT) && !abort;
  assign accept     = collecting && pe_valid[slot_reg];
  assign writing    = (state_reg == WRITE) && !abort;
  assign last_word  = (word_cnt_reg == num_words_reg - ADDR_W'(1));

  // pe_ready depends only on registered state and abort, never on pe_valid
  assign pe_ready    = collecting ? slot_onehot : 4'b0000;
  assign pk_in_valid = accept;
  assign pk_in_data  = accept ? pe_word[slot_reg] : 24'd0;
  assign pk_clear    = (state_reg == CLEAR) || (active && abort);
  assign wr_en       = writing;
  assign wr_addr     = (state_reg == WRITE) ? base_addr_reg + word_cnt_reg : '0;
  assign wr_data     = (state_reg == WRITE) ? pk_out_data : 32'd0;
  assign busy        = active;
  assign done        = (state_reg == DONE) && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      slot_reg      <= 2'd0;
      word_cnt_reg  <= '0;
      num_words_reg <= '0;
      base_addr_reg <= '0;
    end else if (active && abort) begin
      state_reg    <= IDLE;
      slot_reg     <= 2'd0;
      word_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              num_words_reg <= num_words;
              base_addr_reg <= base_addr;
              state_reg     <= CLEAR;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        CLEAR: begin
          slot_reg     <= 2'd0;
          word_cnt_reg <= '0;
          state_reg    <= COLLECT;
        end
        COLLECT: begin
          if (pe_valid[slot_reg]) begin
            slot_reg <= slot_reg + 2'd1;
            if (slot_reg == 2'd3) begin
              state_reg <= WRITE;
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            state_reg <= DONE;
          end else begin
            word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
            state_reg    <= COLLECT;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pack_ctrl.sv
// Directed bench for pack_ctrl with a behavioural 4-byte packer in the loop.
module tb_pack_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] num_words = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [3:0]        pe_valid = 4'b0;
  logic [95:0]       pe_data = '0;
  logic [3:0]        pe_ready;
  logic              pk_in_valid;
  logic              pk_clear;
  logic [23:0]       pk_in_data;
  logic [31:0]       pk_out_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;

  pack_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_words(num_words), .base_addr(base_addr),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
    .pk_in_valid(pk_in_valid), .pk_clear(pk_clear), .pk_in_data(pk_in_data),
    .pk_out_data(pk_out_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // packer: byte pointer cleared by pk_clear, one byte stored per strobe
  logic [7:0] pk_bytes [4];
  logic [1:0] pk_ptr;
  always @(posedge clk) begin
    if (!rst_n) begin
      pk_ptr <= 2'd0;
      pk_bytes[0] <= 8'd0;
      pk_bytes[1] <= 8'd0;
      pk_bytes[2] <= 8'd0;
      pk_bytes[3] <= 8'd0;
    end else if (pk_clear) begin
      pk_ptr <= 2'd0;
    end else if (pk_in_valid) begin
      pk_bytes[pk_ptr] <= pk_in_data[7:0];
      pk_ptr <= pk_ptr + 2'd1;
    end
  end
  assign pk_out_data = {pk_bytes[3], pk_bytes[2], pk_bytes[1], pk_bytes[0]};

  logic [72:0] outs;
  assign outs = {pe_ready, pk_in_valid, pk_clear, pk_in_data, wr_en, wr_addr,
                 wr_data, busy, done};

  int checks = 0;
  int errors = 0;

  function automatic logic [72:0] mk(input logic [3:0] rdy, input logic piv,
                                     input logic clr, input logic [23:0] pid,
                                     input logic we, input logic [7:0] wa,
                                     input logic [31:0] wd, input logic bsy,
                                     input logic dn);
    return {rdy, piv, clr, pid, we, wa, wd, bsy, dn};
  endfunction

  task automatic chk(input string name, input logic [72:0] got, input logic [72:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic cyc(input logic s, input logic a, input logic [3:0] v);
    @(negedge clk);
    start    = s;
    abort    = a;
    pe_valid = v;
    #1;
  endtask

  // PE k carries byte k of w in its low 8 bits; upper 16 bits are tagged junk
  task automatic set_data(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      pe_data[k*24 +: 24] = {8'hA5, 8'(k), w[k*8 +: 8]};
    end
  endtask

  typedef struct {
    logic        s;
    logic        a;
    logic [3:0]  v;
    logic [72:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // single word: base 0x10, bytes 11,22,33,44, all PEs valid
    tbl[0] = '{1'b1, 1'b0, 4'hF, mk(4'h0, 0, 0, 24'h0, 0, 8'h00, 32'h0, 0, 0)};
    tbl[1] = '{1'b0, 1'b0, 4'hF, mk(4'h0, 0, 1, 24'h0, 0, 8'h00, 32'h0, 1, 0)};
    tbl[2] = '{1'b0, 1'b0, 4'hF, mk(4'h1, 1, 0, 24'hA50011, 0, 8'h00, 32'h0, 1, 0)};
    tbl[3] = '{1'b0, 1'b0, 4'hF, mk(4'h2, 1, 0, 24'hA50122, 0, 8'h00, 32'h0, 1, 0)};
    tbl[4] = '{1'b0, 1'b0, 4'hF, mk(4'h4, 1, 0, 24'hA50233, 0, 8'h00, 32'h0, 1, 0)};
    tbl[5] = '{1'b0, 1'b0, 4'hF, mk(4'h8, 1, 0, 24'hA50344, 0, 8'h00, 32'h0, 1, 0)};
    tbl[6] = '{1'b0, 1'b0, 4'hF, mk(4'h0, 0, 0, 24'h0, 1, 8'h10, 32'h44332211, 1, 0)};
    tbl[7] = '{1'b0, 1'b0, 4'hF, mk(4'h0, 0, 0, 24'h0, 0, 8'h00, 32'h0, 1, 1)};
    tbl[8] = '{1'b0, 1'b0, 4'hF, mk(4'h0, 0, 0, 24'h0, 0, 8'h00, 32'h0, 0, 0)};

    rst_n = 1'b0;
    cyc(0, 0, 4'h0);
    cyc(0, 0, 4'h0);
    chk("reset_outputs", outs, '0);
    rst_n = 1'b1;

    num_words = 8'd1;
    base_addr = 8'h10;
    set_data(32'h44332211);
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s, tbl[i].a, tbl[i].v);
      chk($sformatf("single_c%0d", i), outs, tbl[i].exp);
    end

    // three words across the address wrap
    num_words = 8'd3;
    base_addr = 8'hFE;
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("w3_clear", {72'd0, pk_clear}, 73'd1);
    for (int w = 0; w < 3; w++) begin
      set_data({8'(w*4+4), 8'(w*4+3), 8'(w*4+2), 8'(w*4+1)});
      for (int k = 0; k < 4; k++) begin
        cyc(0, 0, 4'hF);
        chk($sformatf("w3_word%0d_slot%0d", w, k), {pe_ready, pk_in_valid, wr_en},
            {4'(1 << k), 1'b1, 1'b0});
      end
      cyc(0, 0, 4'hF);
      chk($sformatf("w3_write%0d", w), {wr_en, wr_addr, wr_data},
          {1'b1, 8'(8'hFE + w), 8'(w*4+4), 8'(w*4+3), 8'(w*4+2), 8'(w*4+1)});
    end
    cyc(0, 0, 4'hF);
    chk("w3_done_c17", {wr_en, busy, done}, 3'b011);
    cyc(0, 0, 4'hF);
    chk("w3_idle", {busy, done}, 2'b00);

    // PE1 stalls while PE2/PE3 are already valid
    num_words = 8'd1;
    base_addr = 8'h20;
    set_data(32'hDDCCBBAA);
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'b1101);
    chk("stall_slot0", {pe_ready, pk_in_valid}, {4'b0001, 1'b1});
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 4'b1100);
      chk($sformatf("stall_hold%0d", i), {pe_ready, pk_in_valid}, {4'b0010, 1'b0});
    end
    cyc(0, 0, 4'hF);
    chk("stall_slot1", {pe_ready, pk_in_valid, pk_in_data}, {4'b0010, 1'b1, 24'hA501BB});
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("stall_slot3", {pe_ready, pk_in_valid}, {4'b1000, 1'b1});
    cyc(0, 0, 4'hF);
    chk("stall_write", {wr_en, wr_addr, wr_data}, {1'b1, 8'h20, 32'hDDCCBBAA});
    cyc(0, 0, 4'hF);
    chk("stall_done", {busy, done}, 2'b11);

    // abort after two bytes accepted, then a clean follow-up job
    base_addr = 8'h30;
    set_data(32'hF0E0D0C0);
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 1, 4'hF);
    chk("abort_cycle", {pe_ready, pk_in_valid, pk_clear, wr_en, busy, done},
        {4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    cyc(0, 0, 4'hF);
    chk("abort_idle", outs, '0);
    base_addr = 8'h31;
    set_data(32'h88776655);
    cyc(1, 0, 4'hF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("after_abort_write", {wr_en, wr_addr, wr_data}, {1'b1, 8'h31, 32'h88776655});
    cyc(0, 0, 4'hF);
    chk("after_abort_done", {busy, done}, 2'b11);

    // zero-length job
    num_words = 8'd0;
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("zero_done_c1", {pk_clear, wr_en, busy, done}, 4'b0011);
    cyc(0, 0, 4'hF);
    chk("zero_idle", outs, '0);

    // start while busy is ignored
    num_words = 8'd1;
    base_addr = 8'h40;
    set_data(32'h0D0C0B0A);
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    num_words = 8'd5;
    base_addr = 8'h99;
    cyc(1, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("busy_start_write", {wr_en, wr_addr, wr_data}, {1'b1, 8'h40, 32'h0D0C0B0A});
    cyc(0, 0, 4'hF);
    chk("busy_start_done", {busy, done}, 2'b11);
    cyc(0, 0, 4'hF);
    chk("busy_start_idle", outs, '0);

    // reset asserted during WRITE
    num_words = 8'd1;
    base_addr = 8'h50;
    set_data(32'h5A5B5C5D);
    cyc(1, 0, 4'hF);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'hF);
    cyc(0, 0, 4'hF);
    chk("rst_write", {wr_en, wr_addr, wr_data}, {1'b1, 8'h50, 32'h5A5B5C5D});
    rst_n = 1'b0;
    cyc(0, 0, 4'hF);
    chk("rst_mid_write", outs, '0);
    rst_n = 1'b1;
    cyc(0, 0, 4'hF);
    chk("rst_after", outs, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pack_ctrl.md
# pack_ctrl

Sequencer that shares the 4-byte output packer among the four PE result ports. It pulls one result per PE in fixed slot order (PE0..PE3) into the packer and writes the completed 32-bit word to output SRAM at an incrementing address. It repeats this for a programmed number of words, then pulses `done`. It sits between the PE array and the output buffer write port.

## Interface
Parameters:
- `ADDR_W`, default 8: width of the SRAM word address and of the word count.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begin a job. Sampled only in IDLE.
- `abort`, input, 1: cancel the job in progress; returns the block to IDLE.
- `num_words`, input, ADDR_W: number of 32-bit words in the job. Latched on `start`.
- `base_addr`, input, ADDR_W: SRAM address of the first word. Latched on `start`.
- `pe_valid`, input, 4: bit i means PE i has a result available.
- `pe_data`, input, 96: PE i's result is on `[i*24 +: 24]`.
- `pe_ready`, output, 4: one-hot; bit i means the block accepts from PE i this cycle.
- `pk_in_valid`, output, 1: packer write strobe.
- `pk_clear`, output, 1: packer clear strobe.
- `pk_in_data`, output, 24: data to the packer; the packer consumes bits [7:0].
- `pk_out_data`, input, 32: packed word from the packer; byte k is on `[k*8 +: 8]`.
- `wr_en`, output, 1: SRAM write strobe.
- `wr_addr`, output, ADDR_W: SRAM write address.
- `wr_data`, output, 32: SRAM write data.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- Registered state: FSM `{IDLE, CLEAR, COLLECT, WRITE, DONE}`, `slot` (2 bits), `word_cnt` (ADDR_W bits), latched `num_words` and `base_addr`.
- All outputs decode combinationally from registered state plus `pe_valid` and `abort`.
- IDLE:
  - `start`=1 and `num_words`≠0: latch inputs, go to CLEAR.
  - `start`=1 and `num_words`=0: go directly to DONE.
  - `start` in any other state is ignored.
- CLEAR:
  - `pk_clear`=1 for one cycle; `slot`<=0, `word_cnt`<=0; go to COLLECT.
  - This realigns the packer's internal byte pointer with `slot`.
- COLLECT:
  - `pe_ready`=1<<`slot`.
  - Handshake occurs when `pe_valid[slot]`=1. In that cycle: `pk_in_valid`=1, `pk_in_data`=`pe_data[slot*24 +: 24]`, `slot`<=`slot`+1 (wraps to 0).
  - Handshake with `slot`=3: go to WRITE.
  - No handshake: hold. Other PEs' `pe_valid` bits are ignored (strict order, no skipping).
- WRITE:
  - `wr_en`=1, `wr_addr`=`base_addr`+`word_cnt` (mod 2^ADDR_W, wraps), `wr_data`=`pk_out_data`.
  - `pe_ready`=0 and `pk_in_valid`=0.
  - If `word_cnt`=`num_words`-1, go to DONE; otherwise `word_cnt`++ and go to COLLECT.
- DONE: `done`=1 for one cycle, `busy`=1; go to IDLE.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE.
  - That same cycle: `pk_clear`=1, and `pe_ready`, `pk_in_valid` and `wr_en` are forced to 0.
  - No `done` pulse.
  - `abort` in IDLE has no effect and overrides nothing.
- Byte mapping: the low 8 bits of PE k's result land in `wr_data[k*8 +: 8]`. The upper 16 bits of each result are passed to the packer and dropped there.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `slot`=0, `word_cnt`=0.
  - Every output is 0: `pe_ready`, `pk_in_valid`, `pk_clear`, `pk_in_data`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`.
  - Reset mid-job discards the job. The packer is reset by the same `rst_n`.
- `start` sampled at cycle 0: CLEAR in cycle 1, first COLLECT in cycle 2.
- With all `pe_valid` held high: handshakes in cycles 2–5, WRITE in cycle 6, next COLLECT in cycle 7.
  - Each word takes 5 cycles.
  - `done` is high in cycle 2+5N for an N-word job.
  - `busy` is high in cycles 1 through 2+5N.
- `num_words`=0: `done` in cycle 1, no `wr_en`, no `pk_clear`.
- `wr_data` is valid in WRITE because the packer has registered the 4th byte at the end of the preceding COLLECT cycle.
- `pe_ready` does not depend on `pe_valid`, so there is no combinational loop through the PEs.
- A PE stall holds `slot` with no timeout. Only `abort` or reset leaves a stall.
- Maximum job: `num_words`=2^ADDR_W-1 words. `word_cnt` never overflows.

## Test plan
- Single word:
  - Stimulus: `base_addr`=0x10, `num_words`=1, `pe_data` low bytes PE0..3 = 0x11,0x22,0x33,0x44, all valid.
  - Response: one `wr_en` in cycle 6 with `wr_addr`=0x10, `wr_data`=0x44332211; `done` in cycle 7.
- Three words with changing data:
  - Stimulus: `base_addr`=0xFE, ADDR_W=8, `num_words`=3.
  - Response: writes to 0xFE, 0xFF, 0x00 (wrap), 5 cycles apart; `done` in cycle 17.
- Out-of-order availability:
  - Stimulus: PE2 and PE3 valid first, PE1 delayed 3 cycles.
  - Response: `pe_ready` stays 0b0010 until PE1 is valid; byte order is unchanged; `wr_data` is correct.
- Abort mid-COLLECT:
  - Stimulus: `abort` after 2 bytes have been accepted.
  - Response: `pk_clear` pulses; IDLE on the next cycle; no `wr_en`, no `done`. A following 1-word job writes the correct word.
- `num_words`=0, and `start` while busy:
  - Response: `done` in cycle 1 with no writes. A `start` pulse while busy changes nothing.
- Reset mid-WRITE:
  - Response: all outputs are 0 on the next cycle and `busy`=0.
